// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  // Fetches are always 4-byte accesses.
  localparam logic [2:0] MSIZE4 = 3'b010;

  function automatic grant_t other_grant(input grant_t g);
    return (g == GNT_I) ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Two-input requester chooser: fixed priority (data wins) or round-robin
// against the previous grant when both requesters are eligible.
module arb_pick
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ARB_MODE = 0
) (
  input  logic   elig_i,
  input  logic   elig_d,
  input  grant_t last_grant,
  output logic   gnt_valid,
  output grant_t gnt
);

  // Pick a winner from the eligibility bits.
  always_comb begin
    gnt_valid = elig_i | elig_d;
    gnt       = GNT_I;
    if (elig_i && elig_d) begin
      if (ARB_MODE == 0) begin
        gnt = GNT_D;
      end else begin
        gnt = other_grant(last_grant);
      end
    end else if (elig_d) begin
      gnt = GNT_D;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory port between the fetch and load/store units.
// One transaction at a time, latched onto the bus, response routed back to
// its owner, optional watchdog abort on a stalled bus.
//
// state  | meaning
// IDLE   | no bus cycle; arbitrate eligible requests
// BUSY_I | fetch transaction on the bus, waiting for bus_ready
// BUSY_D | data transaction on the bus, waiting for bus_ready
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 256,
  parameter int CNT_W    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [63:0] i_addr,
  output logic        i_data_ok,
  output logic [31:0] i_data,
  output logic        i_err,
  input  logic        d_valid,
  input  logic        d_write,
  input  logic [2:0]  d_size,
  input  logic [63:0] d_addr,
  input  logic [7:0]  d_strobe,
  input  logic [63:0] d_wdata,
  output logic        d_data_ok,
  output logic [63:0] d_rdata,
  output logic        d_err,
  output logic        bus_valid,
  output logic        bus_write,
  output logic [2:0]  bus_size,
  output logic [63:0] bus_addr,
  output logic [7:0]  bus_strobe,
  output logic [63:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [63:0] bus_rdata
);

  localparam bit              WDOG_EN = (TIMEOUT != 0);
  localparam int              TC_INT  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TC_INT);

  arb_state_t       state, state_nxt;
  grant_t           last_grant;
  grant_t           pick_gnt;
  logic             pick_valid;
  logic             elig_i, elig_d;
  logic             take_grant;
  logic             done, abort;
  logic             busy;
  logic [CNT_W-1:0] cnt;

  // A requester whose response is being delivered this cycle is not
  // eligible, so a still-held valid cannot trigger a duplicate grant.
  assign elig_i = i_valid & ~i_data_ok;
  assign elig_d = d_valid & ~d_data_ok;

  assign busy      = (state != IDLE);
  assign bus_valid = busy;

  arb_pick #(
    .ARB_MODE (ARB_MODE)
  ) u_pick (
    .elig_i     (elig_i),
    .elig_d     (elig_d),
    .last_grant (last_grant),
    .gnt_valid  (pick_valid),
    .gnt        (pick_gnt)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; bus_ready takes precedence over a watchdog expiry.
  always_comb begin
    state_nxt  = state;
    take_grant = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          take_grant = 1'b1;
          state_nxt  = (pick_gnt == GNT_D) ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (WDOG_EN && (cnt == CNT_TC)) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the granted request onto the bus; held stable while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_write  <= 1'b0;
      bus_size   <= 3'b000;
      bus_addr   <= 64'd0;
      bus_strobe <= 8'd0;
      bus_wdata  <= 64'd0;
      last_grant <= GNT_I;
    end else if (take_grant) begin
      last_grant <= pick_gnt;
      if (pick_gnt == GNT_D) begin
        bus_write  <= d_write;
        bus_size   <= d_size;
        bus_addr   <= d_addr;
        bus_strobe <= d_strobe;
        bus_wdata  <= d_wdata;
      end else begin
        bus_write  <= 1'b0;
        bus_size   <= MSIZE4;
        bus_addr   <= i_addr;
        bus_strobe <= 8'd0;
        bus_wdata  <= 64'd0;
      end
    end
  end

  // Watchdog: cleared on grant, counts busy cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (take_grant) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Route the response to the owner; data holds until that port's next pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_data_ok <= 1'b0;
      i_err     <= 1'b0;
      i_data    <= 32'd0;
      d_data_ok <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= 64'd0;
    end else begin
      i_data_ok <= 1'b0;
      i_err     <= 1'b0;
      d_data_ok <= 1'b0;
      d_err     <= 1'b0;
      if ((state == BUSY_I) && (done || abort)) begin
        i_data_ok <= 1'b1;
        i_err     <= abort;
        if (abort) begin
          i_data <= 32'd0;
        end else begin
          i_data <= bus_addr[2] ? bus_rdata[63:32] : bus_rdata[31:0];
        end
      end
      if ((state == BUSY_D) && (done || abort)) begin
        d_data_ok <= 1'b1;
        d_err     <= abort;
        d_rdata   <= (abort || bus_write) ? 64'd0 : bus_rdata;
      end
    end
  end

endmodule
